// File: rtl/ddr_port_arbiter_pkg.sv
// ddr_port_arbiter_pkg: shared encodings and widths for the DDR port arbiter slice
package ddr_port_arbiter_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WR_GNT = 2'b01;
  localparam logic [1:0] RD_GNT = 2'b10;
  typedef enum logic {OWNER_WR = 1'b0, OWNER_RD = 1'b1} owner_e;
endpackage

// File: rtl/ddr_port_arbiter_if.sv
// ddr_port_arbiter_if: record/replay requester ports plus the DDR bridge port
interface ddr_port_arbiter_if;
  import ddr_port_arbiter_pkg::*;
  logic wr_req;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_writedata;
  logic [BE_W-1:0] wr_byteenable;
  logic wr_waitrequest;
  logic rd_req;
  logic [ADDR_W-1:0] rd_address;
  logic rd_waitrequest;
  logic rd_readdatavalid;
  logic [DATA_W-1:0] rd_readdata;
  logic [ADDR_W-1:0] ddr_address;
  logic ddr_write;
  logic [DATA_W-1:0] ddr_writedata;
  logic [BE_W-1:0] ddr_byteenable;
  logic ddr_read;
  logic ddr_waitrequest;
  logic ddr_readdatavalid;
  logic [DATA_W-1:0] ddr_readdata;
  modport slave (
    input wr_req, wr_address, wr_writedata, wr_byteenable, rd_req, rd_address,
          ddr_waitrequest, ddr_readdatavalid, ddr_readdata,
    output wr_waitrequest, rd_waitrequest, rd_readdatavalid, rd_readdata,
           ddr_address, ddr_write, ddr_writedata, ddr_byteenable, ddr_read
  );
  modport master (
    output wr_req, wr_address, wr_writedata, wr_byteenable, rd_req, rd_address,
           ddr_waitrequest, ddr_readdatavalid, ddr_readdata,
    input wr_waitrequest, rd_waitrequest, rd_readdatavalid, rd_readdata,
          ddr_address, ddr_write, ddr_writedata, ddr_byteenable, ddr_read
  );
endinterface

// File: rtl/ddr_outstanding_counter.sv
// ddr_outstanding_counter: saturating in-flight read counter with full flag and sticky underflow
module ddr_outstanding_counter #(
  parameter int MAX = 8,
  parameter int W = 8
) (
  input  logic SYS_CLOCK,
  input  logic SYS_RESET,
  input  logic inc,
  input  logic dec,
  output logic [W-1:0] count,
  output logic full,
  output logic err_underflow
);
  assign full = count >= MAX[W-1:0];
  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET)
    if (!SYS_RESET) begin
      count <= '0;
      err_underflow <= 1'b0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count == '0 ? '0 : count - 1'b1;
      err_underflow <= err_underflow | (count == '0);
    end
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares one DDR3 Avalon-MM port between record writes and replay reads
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int GRANT_MAX = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic SYS_CLOCK,
  input  logic SYS_RESET,
  ddr_port_arbiter_if.slave bus,
  output logic [1:0] grant,
  output logic [7:0] rd_outstanding,
  output logic err_underflow
);
  logic [1:0] state, state_nx;
  logic [7:0] quota;
  owner_e last_owner;
  logic rd_full, wr_cmd, rd_cmd, acc, quota_hit;
  assign wr_cmd = state == WR_GNT && bus.wr_req;
  assign rd_cmd = state == RD_GNT && bus.rd_req && !rd_full;
  assign acc = (wr_cmd || rd_cmd) && !bus.ddr_waitrequest;
  assign quota_hit = acc && quota == 8'(GRANT_MAX - 1);
  assign grant = state;
  assign bus.ddr_write = wr_cmd;
  assign bus.ddr_read = rd_cmd;
  assign bus.ddr_address = state == RD_GNT ? bus.rd_address : bus.wr_address;
  assign bus.ddr_writedata = bus.wr_writedata;
  assign bus.ddr_byteenable = bus.wr_byteenable;
  assign bus.wr_waitrequest = state == WR_GNT ? bus.ddr_waitrequest : 1'b1;
  assign bus.rd_waitrequest = state == RD_GNT ? bus.ddr_waitrequest | rd_full : 1'b1;
  assign bus.rd_readdatavalid = bus.ddr_readdatavalid;
  assign bus.rd_readdata = bus.ddr_readdata;
  // A stalled command never accepts, so quota_hit cannot fire and the grant holds
  always_comb
    state_nx = state == WR_GNT ? (!bus.wr_req ? IDLE : quota_hit && bus.rd_req ? RD_GNT : WR_GNT) :
               state == RD_GNT ? (!bus.rd_req ? IDLE : (quota_hit || rd_full) && bus.wr_req ? WR_GNT : RD_GNT) :
               bus.rd_req && bus.wr_req ? (last_owner == OWNER_WR ? RD_GNT : WR_GNT) :
               bus.rd_req ? RD_GNT : bus.wr_req ? WR_GNT : IDLE;
  always_ff @(posedge SYS_CLOCK or negedge SYS_RESET)
    if (!SYS_RESET) begin
      state <= IDLE;
      quota <= '0;
      last_owner <= OWNER_WR;
    end else begin
      state <= state_nx;
      quota <= state_nx != state || quota_hit ? '0 : quota + 8'(acc);
      last_owner <= state == RD_GNT ? OWNER_RD : state == WR_GNT ? OWNER_WR : last_owner;
    end
  ddr_outstanding_counter #(.MAX(MAX_OUTSTANDING), .W(8)) u_outstanding (
    .SYS_CLOCK(SYS_CLOCK),
    .SYS_RESET(SYS_RESET),
    .inc(rd_cmd && !bus.ddr_waitrequest),
    .dec(bus.ddr_readdatavalid),
    .count(rd_outstanding),
    .full(rd_full),
    .err_underflow(err_underflow)
  );
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed checks of grant, quota, outstanding and reset behaviour
module tb_ddr_port_arbiter;
  logic SYS_CLOCK, SYS_RESET;
  logic [1:0] grant;
  logic [7:0] rd_outstanding;
  logic err_underflow;
  int n_assert = 0;
  int n_fail = 0;
  ddr_port_arbiter_if bus();
  ddr_port_arbiter #(.GRANT_MAX(4), .MAX_OUTSTANDING(8)) dut (
    .SYS_CLOCK(SYS_CLOCK),
    .SYS_RESET(SYS_RESET),
    .bus(bus.slave),
    .grant(grant),
    .rd_outstanding(rd_outstanding),
    .err_underflow(err_underflow)
  );
  initial SYS_CLOCK = 1'b0;
  always #10 SYS_CLOCK = ~SYS_CLOCK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge SYS_CLOCK);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    SYS_RESET = 1'b0;
    bus.wr_req = 0; bus.wr_address = '0; bus.wr_writedata = '0; bus.wr_byteenable = 4'hF;
    bus.rd_req = 0; bus.rd_address = '0;
    bus.ddr_waitrequest = 0; bus.ddr_readdatavalid = 0; bus.ddr_readdata = '0;
    #5;
    chk("rst_grant", grant, 0);
    chk("rst_ddr_write", bus.ddr_write, 0);
    chk("rst_ddr_read", bus.ddr_read, 0);
    chk("rst_wr_wait", bus.wr_waitrequest, 1);
    chk("rst_rd_wait", bus.rd_waitrequest, 1);
    chk("rst_outstanding", rd_outstanding, 0);
    chk("rst_err", err_underflow, 0);
    cyc(); SYS_RESET = 1'b1;
    // write-only stream: one write per cycle, address and data pass through
    cyc(); bus.wr_req = 1; #1;
    chk("wr_idle_grant", grant, 0);
    chk("wr_idle_wait", bus.wr_waitrequest, 1);
    for (int i = 0; i < 40; i++) begin
      cyc(); bus.wr_address = 24'h001000 + 24'(i); bus.wr_writedata = 32'hA5000000 + i; #1;
      chk("wr_grant", grant, 1);
      chk("wr_ddr_write", bus.ddr_write, 1);
      chk("wr_addr", bus.ddr_address, 32'h001000 + i);
      chk("wr_data", bus.ddr_writedata, 32'hA5000000 + i);
      chk("wr_wait", bus.wr_waitrequest, 0);
    end
    cyc(); bus.wr_req = 0; #1;
    chk("wr_drop_write", bus.ddr_write, 0);
    cyc(); #1;
    chk("wr_back_idle", grant, 0);
    cyc(); SYS_RESET = 1'b0;
    cyc(); SYS_RESET = 1'b1;
    // contention from reset: read wins first, then alternate every 4 transfers
    cyc(); bus.wr_req = 1; bus.rd_req = 1; #1;
    chk("alt_idle", grant, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(); #1;
      chk("alt_grant", grant, ((k - 1) / 4) % 2 == 0 ? 2 : 1);
      chk("alt_read", bus.ddr_read, ((k - 1) / 4) % 2 == 0 ? 1 : 0);
      chk("alt_write", bus.ddr_write, ((k - 1) / 4) % 2 == 0 ? 0 : 1);
    end
    cyc(); bus.wr_req = 0; bus.rd_req = 0; #1;
    chk("alt_outstanding", rd_outstanding, 8);
    chk("alt_grant_end", grant, 2);
    for (int j = 0; j < 8; j++) begin
      cyc(); bus.ddr_readdatavalid = 1; bus.ddr_readdata = 32'hD0000000 + j; #1;
      chk("ret_valid", bus.rd_readdatavalid, 1);
      chk("ret_data", bus.rd_readdata, 32'hD0000000 + j);
    end
    cyc(); bus.ddr_readdatavalid = 0; #1;
    chk("drain_outstanding", rd_outstanding, 0);
    chk("drain_err", err_underflow, 0);
    chk("drain_idle", grant, 0);
    // read stream with returns withheld: eight accepted, then held off
    cyc(); bus.rd_req = 1; bus.rd_address = 24'h100000; #1;
    chk("rd_idle", grant, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(); bus.rd_address = 24'h100000 + 24'(i); #1;
      chk("rd_grant", grant, 2);
      chk("rd_read", bus.ddr_read, 1);
      chk("rd_wait", bus.rd_waitrequest, 0);
      chk("rd_addr", bus.ddr_address, 32'h100000 + i);
      chk("rd_count", rd_outstanding, i);
    end
    cyc(); #1;
    chk("full_read", bus.ddr_read, 0);
    chk("full_wait", bus.rd_waitrequest, 1);
    chk("full_count", rd_outstanding, 8);
    cyc(); bus.ddr_readdatavalid = 1; #1;
    chk("full_ret_read", bus.ddr_read, 0);
    cyc(); bus.ddr_readdatavalid = 0; #1;
    chk("refill_count", rd_outstanding, 7);
    chk("refill_read", bus.ddr_read, 1);
    chk("refill_wait", bus.rd_waitrequest, 0);
    cyc(); bus.wr_req = 1; #1;
    chk("full2_count", rd_outstanding, 8);
    chk("full2_read", bus.ddr_read, 0);
    chk("full2_grant", grant, 2);
    cyc(); #1;
    chk("full_switch_grant", grant, 1);
    chk("full_switch_write", bus.ddr_write, 1);
    chk("full_switch_read", bus.ddr_read, 0);
    cyc(); bus.wr_req = 0; bus.rd_req = 0;
    // simultaneous accept and return, then underflow
    repeat (5) begin cyc(); bus.ddr_readdatavalid = 1; end
    cyc(); bus.ddr_readdatavalid = 0; bus.rd_req = 1; #1;
    chk("sim_count3", rd_outstanding, 3);
    chk("sim_idle", grant, 0);
    cyc(); bus.ddr_readdatavalid = 1; #1;
    chk("sim_read", bus.ddr_read, 1);
    chk("sim_grant", grant, 2);
    cyc(); bus.ddr_readdatavalid = 0; bus.rd_req = 0; #1;
    chk("sim_still3", rd_outstanding, 3);
    repeat (3) begin cyc(); bus.ddr_readdatavalid = 1; end
    cyc(); bus.ddr_readdatavalid = 0; #1;
    chk("uf_pre_count", rd_outstanding, 0);
    chk("uf_pre_err", err_underflow, 0);
    cyc(); bus.ddr_readdatavalid = 1; #1;
    chk("uf_valid", bus.rd_readdatavalid, 1);
    cyc(); bus.ddr_readdatavalid = 0; #1;
    chk("uf_count", rd_outstanding, 0);
    chk("uf_err", err_underflow, 1);
    cyc(); #1;
    chk("uf_sticky", err_underflow, 1);
    // quota expiry while the fourth write is stalled
    cyc(); bus.wr_req = 1; bus.rd_req = 1; #1;
    chk("qs_idle", grant, 0);
    repeat (3) begin
      cyc(); #1;
      chk("qs_grant", grant, 1);
      chk("qs_wait", bus.wr_waitrequest, 0);
    end
    repeat (2) begin
      cyc(); bus.ddr_waitrequest = 1; #1;
      chk("qs_stall_grant", grant, 1);
      chk("qs_stall_write", bus.ddr_write, 1);
      chk("qs_stall_wrwait", bus.wr_waitrequest, 1);
      chk("qs_stall_rdwait", bus.rd_waitrequest, 1);
    end
    cyc(); bus.ddr_waitrequest = 0; #1;
    chk("qs_accept_grant", grant, 1);
    chk("qs_accept_wait", bus.wr_waitrequest, 0);
    cyc(); #1;
    chk("qs_switch_grant", grant, 2);
    chk("qs_switch_read", bus.ddr_read, 1);
    chk("qs_switch_write", bus.ddr_write, 0);
    cyc(); bus.wr_req = 0; bus.rd_req = 0;
    // asynchronous reset in the middle of a write burst
    cyc(); bus.wr_req = 1;
    cyc(); bus.wr_address = 24'hABCDEF; #1;
    chk("ar_pre_grant", grant, 1);
    chk("ar_pre_write", bus.ddr_write, 1);
    chk("ar_pre_count", rd_outstanding, 1);
    #2 SYS_RESET = 1'b0; #1;
    chk("ar_write", bus.ddr_write, 0);
    chk("ar_grant", grant, 0);
    chk("ar_count", rd_outstanding, 0);
    chk("ar_err", err_underflow, 0);
    chk("ar_wrwait", bus.wr_waitrequest, 1);
    cyc(); SYS_RESET = 1'b1; bus.wr_req = 0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
